sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It is the next generation of the fixed 8-bit x 16 FIFO, with configurable width and depth. It adds an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. It sits between any producer/consumer pair in the same clock domain and exposes its pointers for debug.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 4, address width; depth DEPTH = 2^ADDR_W
AF_THRESH, 14, Almost_full asserts when Count >= AF_THRESH (legal range 1..DEPTH)
AE_THRESH, 2, Almost_empty asserts when Count <= AE_THRESH (legal range 0..DEPTH-1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
W_en  in  1  write request
R_en  in  1  read request
W_data  in  DATA_W  write data
R_data  out  DATA_W  read data
Empty  out  1  Count == 0
Full  out  1  Count == DEPTH
Almost_full  out  1  Count >= AF_THRESH
Almost_empty  out  1  Count <= AE_THRESH
Count  out  ADDR_W+1  current occupancy, 0..DEPTH
Overflow  out  1  sticky: a write was rejected
Underflow  out  1  sticky: a read was rejected
W_Ptr  out  ADDR_W+1  write pointer, with wrap bit
R_Ptr  out  ADDR_W+1  read pointer, with wrap bit

Behaviour:
- Reset: rst=1 at a clk edge forces:
  - W_Ptr=0, R_Ptr=0, Count=0, R_data=0
  - Overflow=0, Underflow=0
  - Empty=1, Full=0, Almost_empty=1, Almost_full=0
- Reset takes priority over W_en/R_en in the same cycle. Reset mid-operation discards all contents. Memory contents need not be cleared.
- Pointers are ADDR_W+1 bits. Memory index is ptr[ADDR_W-1:0]. Pointers wrap from 2^(ADDR_W+1)-1 to 0.
- Read accept: rd_acc = R_en && !Empty.
- Write accept: wr_acc = W_en && (!Full || rd_acc). On Full, a simultaneous read and write are both accepted.
- Accepted write stores W_data at mem[W_Ptr] and increments W_Ptr.
- Accepted read increments R_Ptr.
- Count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged on both or neither
- Empty, Full, Almost_* are combinational decodes of the registered Count. They change in the same cycle as Count.
- Simultaneous R/W on Empty: the read is rejected and the write is accepted, so Count becomes 1.
- Overflow sets when W_en && !wr_acc. Underflow sets when R_en && !rd_acc. Both are cleared only by rst.
- Rejected operations leave pointers, memory and R_data unchanged.
- Read timing, default build: R_data is registered. On rd_acc, R_data <= mem[R_Ptr] at the same edge, i.e. valid 1 cycle after R_en is sampled. R_data holds otherwise.

Optional Feature:
FIFO_FWFT_EN:
- Defined: first-word-fall-through mode.
  - R_data = mem[R_Ptr[ADDR_W-1:0]] combinationally whenever !Empty, and R_data = 0 when Empty.
  - The head word is visible before R_en; R_en pops it.
  - The first written word appears on R_data in the cycle after its write edge.
- Undefined: registered 1-cycle read as described in Behaviour.
- Flags, Count and error behaviour are identical in both modes.

Test Plan:
- Reset, then write 0..15 on 16 consecutive cycles. Required: Almost_full rises when Count=14, Full=1 and Count=16 after the 16th edge, W_Ptr=5'b10000, Empty=0.
- From full, assert R_en for 16 cycles. Required: R_data = 0..15 in order, each one cycle after its read edge; Almost_empty rises at Count=2; Empty=1, R_Ptr=16 at the end.
- Fill to 16, then W_en=1 with W_data=8'hAA and R_en=0. Required: Overflow=1 (sticky), Count=16, W_Ptr unchanged; subsequent reads return 0..15 and no AA.
- With the FIFO empty, R_en=1 for one cycle. Required: Underflow=1, R_data holds its prior value, R_Ptr unchanged. Then simultaneous W_en/R_en: Count becomes 1 and Underflow sets again.
- At Count=16, W_en=R_en=1 with W_data=8'h55. Required: Count stays 16, Full stays 1, no Overflow, and 55 is read out last. Repeat at Count=5: Count stays 5.
- Three rounds of 16 writes then 16 reads. Required: pointers wrap 31->0 with data intact. Then write 7 words and assert rst. Required: next edge gives Count=0, Empty=1, flags and pointers zero.
- The whole plan is also run with FIFO_FWFT_EN defined. Required: R_data shows 0 immediately after the first write, before any R_en.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              W_en,
  input  logic              R_en,
  input  logic [DATA_W-1:0] W_data,
  output logic [DATA_W-1:0] R_data,
  output logic              Empty,
  output logic              Full,
  output logic              Almost_full,
  output logic              Almost_empty,
  output logic [ADDR_W:0]   Count,
  output logic              Overflow,
  output logic              Underflow,
  output logic [ADDR_W:0]   W_Ptr,
  output logic [ADDR_W:0]   R_Ptr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_C    = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_THRESH[ADDR_W:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_acc, wr_acc;

  assign Empty        = (count_q == '0);
  assign Full         = (count_q == DEPTH_C);
  assign Almost_full  = (count_q >= AF_C);
  assign Almost_empty = (count_q <= AE_C);
  assign Count        = count_q;
  assign Overflow     = ovf_q;
  assign Underflow    = unf_q;
  assign W_Ptr        = wptr_q;
  assign R_Ptr        = rptr_q;

  // A read frees a slot in the same edge, so a full FIFO still takes a paired write.
  always_comb begin
    rd_acc  = R_en && !Empty;
    wr_acc  = W_en && (!Full || rd_acc);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
    if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
    if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    ovf_d = ovf_q | (W_en && !wr_acc);
    unf_d = unf_q | (R_en && !rd_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wptr_q[ADDR_W-1:0]] <= W_data;
  end

`ifdef FIFO_FWFT_EN
  assign R_data = Empty ? '0 : mem_q[rptr_q[ADDR_W-1:0]];
`else
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst)         rdata_q <= '0;
    else if (rd_acc) rdata_q <= mem_q[rptr_q[ADDR_W-1:0]];
  end

  assign R_data = rdata_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based reference model.
module tb_sync_fifo_param;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AF_TH  = 14;
  localparam int AE_TH  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              W_en = 1'b0;
  logic              R_en = 1'b0;
  logic [DATA_W-1:0] W_data = '0;
  logic [DATA_W-1:0] R_data;
  logic              Empty, Full, Almost_full, Almost_empty, Overflow, Underflow;
  logic [ADDR_W:0]   Count, W_Ptr, R_Ptr;

  sync_fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_THRESH(AF_TH), .AE_THRESH(AE_TH)) dut (
    .clk(clk), .rst(rst), .W_en(W_en), .R_en(R_en), .W_data(W_data), .R_data(R_data),
    .Empty(Empty), .Full(Full), .Almost_full(Almost_full), .Almost_empty(Almost_empty),
    .Count(Count), .Overflow(Overflow), .Underflow(Underflow), .W_Ptr(W_Ptr), .R_Ptr(R_Ptr)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, pointers as counts of accepted operations.
  logic [DATA_W-1:0] q[$];
  int                n_wr, n_rd;
  bit                ovf_m, unf_m;
  logic [DATA_W-1:0] rdata_m;
  int                checks, passes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("count", 32'(Count), 32'(n));
    check("empty", 32'(Empty), 32'(n == 0));
    check("full", 32'(Full), 32'(n == DEPTH));
    check("almost_full", 32'(Almost_full), 32'(n >= AF_TH));
    check("almost_empty", 32'(Almost_empty), 32'(n <= AE_TH));
    check("overflow", 32'(Overflow), 32'(ovf_m));
    check("underflow", 32'(Underflow), 32'(unf_m));
    check("w_ptr", 32'(W_Ptr), 32'(n_wr % (2 * DEPTH)));
    check("r_ptr", 32'(R_Ptr), 32'(n_rd % (2 * DEPTH)));
`ifdef FIFO_FWFT_EN
    check("r_data", 32'(R_data), (n == 0) ? 32'd0 : 32'(q[0]));
`else
    check("r_data", 32'(R_data), 32'(rdata_m));
`endif
  endtask

  // One clock: drive inputs, advance the model by the rules, then check 1 time unit after the edge.
  task automatic step(input bit r_st, input bit w, input bit r, input logic [DATA_W-1:0] d);
    bit rd_ok, wr_ok;
    rst = r_st; W_en = w; R_en = r; W_data = d;
    @(posedge clk);
    if (r_st) begin
      q.delete();
      n_wr = 0; n_rd = 0; ovf_m = 0; unf_m = 0; rdata_m = '0;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < DEPTH) || rd_ok);
      if (w && !wr_ok) ovf_m = 1;
      if (r && !rd_ok) unf_m = 1;
      if (rd_ok) begin rdata_m = q.pop_front(); n_rd++; end
      if (wr_ok) begin q.push_back(d); n_wr++; end
    end
    #1;
    rst = 1'b0; W_en = 1'b0; R_en = 1'b0;
    check_all();
  endtask

  task automatic wr(input logic [DATA_W-1:0] d); step(0, 1, 0, d); endtask
  task automatic rd();                           step(0, 0, 1, '0); endtask

  initial begin
    checks = 0; passes = 0;
    q.delete(); n_wr = 0; n_rd = 0; ovf_m = 0; unf_m = 0; rdata_m = '0;
    @(negedge clk);
    step(1, 0, 0, '0);
    step(1, 1, 1, 8'h11);

    for (int i = 0; i < 16; i++) wr(8'(i));
    check("fill_wptr", 32'(W_Ptr), 32'h10);
    for (int i = 0; i < 16; i++) rd();
    check("drain_rptr", 32'(R_Ptr), 32'h10);

    for (int i = 0; i < 16; i++) wr(8'(i));
    wr(8'hAA);
    check("ovf_sticky", 32'(Overflow), 32'd1);
    for (int i = 0; i < 16; i++) rd();

    rd();
    check("unf_rptr", 32'(R_Ptr), 32'(n_rd % 32));
    step(0, 1, 1, 8'h33);
    rd();

    for (int i = 0; i < 16; i++) wr(8'(i));
    step(0, 1, 1, 8'h55);
    for (int i = 0; i < 16; i++) rd();
    check("last_is_55", 32'(rdata_m), 32'h55);
    for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
    step(0, 1, 1, 8'h66);
    check("pair_at_5", 32'(Count), 32'd5);
    for (int i = 0; i < 5; i++) rd();

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) wr(8'($urandom_range(0, 255)));
      for (int i = 0; i < 16; i++) rd();
    end

    step(1, 0, 0, '0);
    for (int i = 0; i < 7; i++) wr(8'(i + 1));
    step(1, 1, 1, 8'h77);
    check("rst_count", 32'(Count), 32'd0);

`ifdef FIFO_FWFT_EN
    wr(8'h00);
    check("fwft_head", 32'(R_data), 32'd0);
    step(1, 0, 0, '0);
`endif

    for (int i = 0; i < 3000; i++) begin
      int mode;
      mode = (i / 300) % 3;
      step(($urandom_range(0, 249) == 0),
           (mode == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1),
           (mode == 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1),
           8'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
